puf_eval_engine: RTL and testbench

Multi-chain arbiter-PUF evaluation engine. It instantiates N_CHAINS switch-box delay lines of C_LENGTH stages, each with an arbiter flop. A control FSM launches REPS excitation pulses per challenge and majority-votes each chain's arbiter result into one response bit. It sits between the challenge source (host/UART command logic) and the response consumer, and delivers a response word plus a per-bit stability flag over a valid/ready handshake.

---
 rtl/puf_eval_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_puf_eval_engine.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_engine.sv
// puf_eval_engine
// Multi-chain arbiter-PUF evaluation engine. N_CHAINS switch-box delay lines
// of C_LENGTH stages race a shared excitation pulse; each chain's arbiter flop
// decides which path arrived first. The control FSM repeats the race REPS
// times per challenge and majority-votes every chain into one response bit,
// also flagging whether all repetitions of that chain agreed.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   start       in   evaluation request, sampled only while idle
//   challenge   in   [C_LENGTH]  challenge word, latched on the accept edge
//   busy        out  high from the accept edge until the response transfers
//   resp_valid  out  response/stable are valid
//   resp_ready  in   consumer accepts the response
//   response    out  [N_CHAINS]  majority-voted response bits
//   stable      out  [N_CHAINS]  bit j set when every repetition of chain j agreed
module puf_eval_engine #(
    parameter int C_LENGTH      = 32,
    parameter int N_CHAINS      = 4,
    parameter int REPS          = 7,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [C_LENGTH-1:0] challenge,
    output logic                busy,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [N_CHAINS-1:0] response,
    output logic [N_CHAINS-1:0] stable
);

    localparam int CW = $clog2(REPS + 1);
    localparam int TW = $clog2(SETTLE_CYCLES);

    localparam logic [CW-1:0] REPS_C   = CW'(REPS);
    localparam logic [CW:0]   REPS_X   = (CW + 1)'(REPS);
    localparam logic [CW-1:0] LAST_REP = CW'(REPS - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [C_LENGTH-1:0]               r_chal;
    logic [N_CHAINS-1:0][CW-1:0]       r_cnt;
    logic [N_CHAINS-1:0][CW-1:0]       w_cnt_inc;
    logic [CW-1:0]                     r_rep;
    logic [TW-1:0]                     r_tmr;
    logic                              w_tmr_done;
    logic                              r_pulse;
    logic                              r_arb_clr;
    logic                              w_pulse_d;
    logic                              w_arb_clr_d;
    logic [N_CHAINS-1:0][C_LENGTH-1:0] w_sel;
    logic [N_CHAINS-1:0]               w_arb;
    (* dont_touch = "true" *) logic [N_CHAINS-1:0] r_sync1;
    (* dont_touch = "true" *) logic [N_CHAINS-1:0] r_sync2;
    logic [N_CHAINS-1:0]               r_response;
    logic [N_CHAINS-1:0]               r_stable;
    logic [N_CHAINS-1:0]               w_resp_d;
    logic [N_CHAINS-1:0]               w_stab_d;

    // ------------------------------------------------------------------
    // Delay lines and arbiters
    // ------------------------------------------------------------------
    for (genvar gj = 0; gj < N_CHAINS; gj++) begin : g_chain
        // Chain j uses the latched challenge rotated left by j bits.
        if (gj == 0) begin : g_rot0
            assign w_sel[gj] = r_chal;
        end else begin : g_rotn
            assign w_sel[gj] = {r_chal[C_LENGTH-1-gj:0], r_chal[C_LENGTH-1:C_LENGTH-gj]};
        end

        // Switch box: select 0 passes straight through, select 1 crosses paths.
        for (genvar gi = 0; gi < C_LENGTH; gi++) begin : g_stage
            logic w_t_in;
            logic w_b_in;
            (* dont_touch = "true" *) logic w_t;
            (* dont_touch = "true" *) logic w_b;

            if (gi == 0) begin : g_src
                assign w_t_in = r_pulse;
                assign w_b_in = r_pulse;
            end else begin : g_link
                assign w_t_in = g_stage[gi-1].w_t;
                assign w_b_in = g_stage[gi-1].w_b;
            end

            assign w_t = w_sel[gj][gi] ? w_b_in : w_t_in;
            assign w_b = w_sel[gj][gi] ? w_t_in : w_b_in;
        end

        logic w_out_1;
        logic w_out_2;
        assign w_out_1 = g_stage[C_LENGTH-1].w_t;
        assign w_out_2 = g_stage[C_LENGTH-1].w_b;

        // Arbiter: captures 1 when out_1 arrived before out_2's rising edge.
        (* dont_touch = "true" *) logic r_arb;
        always_ff @(posedge w_out_2 or posedge r_arb_clr) begin
            if (r_arb_clr) begin
                r_arb <= 1'b0;
            end else begin
                r_arb <= w_out_1;
            end
        end

        assign w_arb[gj] = r_arb;
    end

    // ------------------------------------------------------------------
    // FSM: state register (pulse/arb_clr registered alongside the state)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pulse   <= 1'b0;
            r_arb_clr <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_pulse   <= w_pulse_d;
            r_arb_clr <= w_arb_clr_d;
        end
    end

    // FSM: next state
    assign w_tmr_done = (r_tmr == TMR_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start)      w_state_nxt = S_CLEAR;
            S_CLEAR:  if (w_tmr_done) w_state_nxt = S_LAUNCH;
            S_LAUNCH:                 w_state_nxt = S_WAIT;
            S_WAIT:   if (w_tmr_done) w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = (r_rep == LAST_REP) ? S_DONE : S_CLEAR;
            S_DONE:   if (resp_ready) w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs. Decoded from the next state so that the registered pulse
    // and clear line line up exactly with the state they belong to.
    always_comb begin
        w_pulse_d   = 1'b0;
        w_arb_clr_d = 1'b1;
        case (w_state_nxt)
            S_LAUNCH, S_WAIT, S_SAMPLE: begin
                w_pulse_d   = 1'b1;
                w_arb_clr_d = 1'b0;
            end
            default: begin
                w_pulse_d   = 1'b0;
                w_arb_clr_d = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Vote datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_inc = '0;
        w_resp_d  = '0;
        w_stab_d  = '0;
        for (int unsigned j = 0; j < N_CHAINS; j++) begin
            w_cnt_inc[j] = r_cnt[j] + CW'(r_sync2[j]);
            // 2*cnt > REPS: strict, so an even-REPS tie yields 0.
            w_resp_d[j]  = ({w_cnt_inc[j], 1'b0} > REPS_X);
            w_stab_d[j]  = (w_cnt_inc[j] == '0) || (w_cnt_inc[j] == REPS_C);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chal     <= '0;
            r_cnt      <= '0;
            r_rep      <= '0;
            r_tmr      <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_response <= '0;
            r_stable   <= '0;
        end else begin
            r_sync1 <= w_arb;
            r_sync2 <= r_sync1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_chal <= challenge;
                        r_cnt  <= '0;
                        r_rep  <= '0;
                        r_tmr  <= '0;
                    end
                end
                S_CLEAR, S_WAIT: begin
                    r_tmr <= w_tmr_done ? '0 : r_tmr + TW'(1);
                end
                S_SAMPLE: begin
                    r_cnt <= w_cnt_inc;
                    r_rep <= r_rep + CW'(1);
                    if (r_rep == LAST_REP) begin
                        r_response <= w_resp_d;
                        r_stable   <= w_stab_d;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_DONE);
    assign response   = r_response;
    assign stable     = r_stable;

endmodule

// File: tb/tb_puf_eval_engine.sv
// tb_puf_eval_engine
// Drives two engines (default parameters, and an even-REPS two-chain variant)
// with random challenges. Arbiter decisions are imposed per repetition on the
// engines' arbiter nets; a vote-count model predicts response and stable.
module tb_puf_eval_engine;

    localparam int T_EVAL = 2 * 8 + 2;

    logic clk;
    logic rst_n;

    logic        st  [2];
    logic [31:0] ch  [2];
    logic        rdy [2];

    logic       busy0, val0, busy1, val1;
    logic [3:0] resp0, stab0;
    logic [1:0] resp1, stab1;

    logic       o_busy [2];
    logic       o_val  [2];
    logic [3:0] o_rsp  [2];
    logic [3:0] o_stb  [2];

    logic [3:0] arb0;
    logic [1:0] arb1;

    int n_checks;
    int n_pass;

    puf_eval_engine #(
        .C_LENGTH(32), .N_CHAINS(4), .REPS(7), .SETTLE_CYCLES(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .challenge(ch[0]),
        .busy(busy0), .resp_valid(val0), .resp_ready(rdy[0]),
        .response(resp0), .stable(stab0)
    );

    puf_eval_engine #(
        .C_LENGTH(32), .N_CHAINS(2), .REPS(4), .SETTLE_CYCLES(8)
    ) u_tie (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .challenge(ch[1]),
        .busy(busy1), .resp_valid(val1), .resp_ready(rdy[1]),
        .response(resp1), .stable(stab1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        o_busy[0] = busy0;
        o_val[0]  = val0;
        o_rsp[0]  = resp0;
        o_stb[0]  = stab0;
        o_busy[1] = busy1;
        o_val[1]  = val1;
        o_rsp[1]  = {2'b00, resp1};
        o_stb[1]  = {2'b00, stab1};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_arb(input int inst, input logic [3:0] v);
        if (inst == 0) begin
            arb0 = v;
            force u_dut.w_arb = arb0;
        end else begin
            arb1 = v[1:0];
            force u_tie.w_arb = arb1;
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] c, input int j);
        if (j == 0) return c;
        return (c << j) | (c >> (32 - j));
    endfunction

    function automatic logic [31:0] sel(input int inst, input int j);
        if (inst == 0) return u_dut.w_sel[j];
        return u_tie.w_sel[j];
    endfunction

    // Majority vote over the imposed arbiter decisions.
    function automatic void model(input int reps, input int nch, input logic [3:0] w [$],
                                  output logic [3:0] r, output logic [3:0] s);
        r = '0;
        s = '0;
        for (int j = 0; j < nch; j++) begin
            int c;
            c = 0;
            for (int i = 0; i < reps; i++) c += (w[i][j] ? 1 : 0);
            r[j] = (2 * c > reps);
            s[j] = (c == 0) || (c == reps);
        end
    endfunction

    task automatic run_eval(input int inst, input logic [31:0] chal, input logic [3:0] w [$],
                            input int hold);
        int reps;
        int nch;
        int cyc;
        logic [3:0] er;
        logic [3:0] es;
        reps = (inst == 0) ? 7 : 4;
        nch  = (inst == 0) ? 4 : 2;
        model(reps, nch, w, er, es);
        rdy[inst] = (hold == 0);
        ch[inst]  = chal;
        st[inst]  = 1'b1;
        set_arb(inst, w[0]);
        @(posedge clk); #1;
        st[inst] = 1'b0;
        ch[inst] = $urandom;
        check_eq("busy_accept", 32'(o_busy[inst]), 32'd1);
        for (int j = 0; j < nch; j++) check_eq("rotation", sel(inst, j), rotl(chal, j));
        cyc = 0;
        while (!o_val[inst] && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if ((cyc % T_EVAL) == 0 && (cyc / T_EVAL) < reps) set_arb(inst, w[cyc / T_EVAL]);
        end
        check_eq("latency", 32'(cyc), 32'(reps * T_EVAL));
        check_eq("response", 32'(o_rsp[inst]), 32'(er));
        check_eq("stable", 32'(o_stb[inst]), 32'(es));
        for (int j = 0; j < nch; j++) check_eq("rot_hold", sel(inst, j), rotl(chal, j));
        for (int i = 0; i < hold; i++) begin
            st[inst] = 1'($urandom_range(0, 1));
            ch[inst] = $urandom;
            @(posedge clk); #1;
            check_eq("bp_valid", 32'(o_val[inst]), 32'd1);
            check_eq("bp_busy", 32'(o_busy[inst]), 32'd1);
            check_eq("bp_resp", 32'(o_rsp[inst]), 32'(er));
            check_eq("bp_stable", 32'(o_stb[inst]), 32'(es));
        end
        // Start asserted during the transfer cycle must be ignored.
        st[inst]  = 1'b1;
        rdy[inst] = 1'b1;
        @(posedge clk); #1;
        check_eq("xfer_valid", 32'(o_val[inst]), 32'd0);
        check_eq("xfer_busy", 32'(o_busy[inst]), 32'd0);
        check_eq("hold_resp", 32'(o_rsp[inst]), 32'(er));
        check_eq("hold_stable", 32'(o_stb[inst]), 32'(es));
        st[inst]  = 1'b0;
        rdy[inst] = 1'b0;
    endtask

    initial begin
        logic [3:0] w [$];
        int         mode [4];
        int         cyc;
        logic       seen;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st[i]  = 1'b0;
            ch[i]  = '0;
            rdy[i] = 1'b0;
        end
        set_arb(0, 4'b0000);
        set_arb(1, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_valid", 32'(val0), 32'd0);
        check_eq("rst_resp", 32'(resp0), 32'd0);
        check_eq("rst_stable", 32'(stab0), 32'd0);
        check_eq("rst_pulse", 32'(u_dut.r_pulse), 32'd0);
        check_eq("rst_arb_clr", 32'(u_dut.r_arb_clr), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fixed skew: chains 0 and 2 always won by out_1.
        w = {};
        repeat (7) w.push_back(4'b0101);
        run_eval(0, 32'hA5A5A5A5, w, 0);

        // Reset in the middle of WAIT.
        ch[0] = $urandom;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_eq("pulse_wait", 32'(u_dut.r_pulse), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy0), 32'd0);
        check_eq("abort_valid", 32'(val0), 32'd0);
        check_eq("abort_resp", 32'(resp0), 32'd0);
        check_eq("abort_stable", 32'(stab0), 32'd0);
        check_eq("abort_pulse", 32'(u_dut.r_pulse), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        check_eq("start_after_rst", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        seen = 1'b0;
        cyc  = 0;
        while (cyc < 140) begin
            @(posedge clk); #1;
            cyc++;
            if (val0) seen = 1'b1;
        end
        check_eq("abort_no_resp", 32'(seen), 32'd0);
        check_eq("abort_idle", 32'(busy0), 32'd0);

        // Noisy chain 1: wins on repetitions 0,2,4,6 then 0,2,4.
        w = {};
        for (int r = 0; r < 7; r++) w.push_back(((r % 2) == 0) ? 4'b1011 : 4'b1001);
        run_eval(0, $urandom, w, 0);
        w = {};
        for (int r = 0; r < 7; r++) w.push_back(((r % 2) == 0 && r < 6) ? 4'b0010 : 4'b0000);
        run_eval(0, $urandom, w, 0);

        // Even REPS: chain 0 wins 2 of 4 (tie), chain 1 wins 3 of 4.
        w = {};
        w.push_back(4'b0011);
        w.push_back(4'b0011);
        w.push_back(4'b0010);
        w.push_back(4'b0000);
        run_eval(1, 32'h0000_0001, w, 0);

        // Backpressure for 50 cycles.
        w = {};
        for (int r = 0; r < 7; r++) w.push_back(4'($urandom));
        run_eval(0, $urandom, w, 50);

        // Random campaigns: per chain, always 0, always 1, or noisy.
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 4; j++) mode[j] = $urandom_range(0, 2);
            w = {};
            for (int r = 0; r < 7; r++) begin
                logic [3:0] v;
                for (int j = 0; j < 4; j++)
                    v[j] = (mode[j] == 2) ? 1'($urandom) : (mode[j] == 1);
                w.push_back(v);
            end
            run_eval(0, $urandom, w, $urandom_range(0, 3));
        end
        for (int k = 0; k < 3; k++) begin
            w = {};
            for (int r = 0; r < 4; r++) w.push_back({2'b00, 2'($urandom)});
            run_eval(1, $urandom, w, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
